// File: rtl/gf_log.sv
// Sequential discrete log for GF(2^6): finds k with alpha^k == a
// by stepping alpha^k with one multiply-by-x per clock.
module gf_log #(
    parameter logic [5:0] POLY = 6'b000011
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       start,
    input  logic [5:0] a,
    output logic [5:0] log_out,
    output logic       finish_flag,
    output logic       log_err
);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        ZERO_CHK,
        DONE
    } state_t;

    state_t     state, state_nx;
    logic [5:0] cur, cur_nx;
    logic [5:0] k, k_nx;
    logic [5:0] a_reg, a_reg_nx;
    logic [5:0] log_nx;
    logic       fin_nx;
    logic       err_nx;

    // Multiply by x, reducing by the primitive polynomial
    function automatic logic [5:0] xtime(input logic [5:0] c);
        logic [5:0] sh;
        sh = {c[4:0], 1'b0};
        return c[5] ? (sh ^ POLY) : sh;
    endfunction

    // State and datapath registers; reset aborts any search
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            cur         <= 6'b000001;
            k           <= 6'd0;
            a_reg       <= 6'd0;
            log_out     <= 6'd0;
            finish_flag <= 1'b1;
            log_err     <= 1'b0;
        end else begin
            state       <= state_nx;
            cur         <= cur_nx;
            k           <= k_nx;
            a_reg       <= a_reg_nx;
            log_out     <= log_nx;
            finish_flag <= fin_nx;
            log_err     <= err_nx;
        end
    end

    // Next-state and output logic; start overrides everything
    always_comb begin
        state_nx = state;
        cur_nx   = cur;
        k_nx     = k;
        a_reg_nx = a_reg;
        log_nx   = log_out;
        fin_nx   = finish_flag;
        err_nx   = log_err;
        if (start) begin
            a_reg_nx = a;
            cur_nx   = 6'b000001;
            k_nx     = 6'd0;
            fin_nx   = 1'b0;
            err_nx   = 1'b0;
            state_nx = (a == 6'd0) ? ZERO_CHK : SEARCH;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                end
                ZERO_CHK: begin
                    log_nx   = 6'd0;
                    err_nx   = 1'b1;
                    fin_nx   = 1'b1;
                    state_nx = DONE;
                end
                SEARCH: begin
                    if (cur == a_reg) begin
                        log_nx   = k;
                        fin_nx   = 1'b1;
                        state_nx = DONE;
                    end else if (k == 6'd62) begin
                        log_nx   = 6'd0;
                        err_nx   = 1'b1;
                        fin_nx   = 1'b1;
                        state_nx = DONE;
                    end else begin
                        cur_nx = xtime(cur);
                        k_nx   = k + 6'd1;
                    end
                end
            endcase
        end
    end

endmodule
